// File: rtl/sync_fifo_ex.sv
// Single-clock FIFO with level, threshold flags and sticky over/underflow errors.
// Define SYNC_FIFO_FWFT_EN for show-ahead read data; default is 1-cycle registered reads.
module sync_fifo_ex #(
  parameter int unsigned p_WIDTH    = 8,
  parameter int unsigned p_CAPACITY = 16,
  parameter int unsigned p_AF_LEVEL = 12,
  parameter int unsigned p_AE_LEVEL = 4
) (
  input  logic                              iw_clk,
  input  logic                              iw_reset_n,
  input  logic [p_WIDTH-1:0]                wrdata,
  input  logic                              wrena,
  input  logic                              rdena,
  input  logic                              clr_err,
  output logic [p_WIDTH-1:0]                rddata,
  output logic                              rdvalid,
  output logic [$clog2(p_CAPACITY+1)-1:0]   level,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int unsigned PW = (p_CAPACITY > 1) ? $clog2(p_CAPACITY) : 1;
  localparam int unsigned LW = $clog2(p_CAPACITY + 1);

  localparam logic [LW-1:0] CAP_LVL = LW'(p_CAPACITY);
  localparam logic [LW-1:0] AF_LVL  = LW'(p_AF_LEVEL);
  localparam logic [LW-1:0] AE_LVL  = LW'(p_AE_LEVEL);
  localparam logic [PW-1:0] LAST_PTR = PW'(p_CAPACITY - 1);

  logic [p_WIDTH-1:0] mem [p_CAPACITY];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               wr_accept;
  logic               rd_accept;

  // A full FIFO refuses writes even when a read frees a slot in the same cycle.
  assign wr_accept = wrena & ~full;
  assign rd_accept = rdena & ~empty;

  assign full         = (level == CAP_LVL);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  // NOTE: storage has no reset so it maps onto plain RAM; stale words are unreachable once level is 0.
  always_ff @(posedge iw_clk) begin
    if (wr_accept) mem[wr_ptr] <= wrdata;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iw_clk or negedge iw_reset_n) begin
    if (!iw_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

      case ({wr_accept, rd_accept})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // Set has priority over clear.
      if (wrena && full)       overflow <= 1'b1;
      else if (clr_err)        overflow <= 1'b0;
      if (rdena && empty)      underflow <= 1'b1;
      else if (clr_err)        underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible directly; masked while empty so reset shows zero immediately.
  assign rddata  = empty ? '0 : mem[rd_ptr];
  assign rdvalid = ~empty;
`else
  always_ff @(posedge iw_clk or negedge iw_reset_n) begin
    if (!iw_reset_n) begin
      rddata  <= '0;
      rdvalid <= 1'b0;
    end else begin
      rdvalid <= rd_accept;
      if (rd_accept) rddata <= mem[rd_ptr];
    end
  end
`endif

endmodule
